// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request port: controller drives req/adrx,
// memory returns a one-cycle ack with read data.
interface ifetch_ctrl_if #(
   parameter int ADDR_W  = 9,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_adrx;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req, imem_adrx,
      input  imem_ack, imem_rdata
   );

   modport slave (
      input  imem_req, imem_adrx,
      output imem_ack, imem_rdata
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns pc, issues imem fetches, handles redirects.
// Optional IFETCH_ALIGN_CHECK_EN turns misaligned branches into a fault halt.
module ifetch_ctrl #(
   parameter int                ADDR_W     = 9,
   parameter int                INSTR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_i,
   input  logic               stall_i,
   input  logic               branch_i,
   input  logic [ADDR_W-1:0]  branch_adrx_i,
   input  logic               halt_i,
   ifetch_ctrl_if.master      imem,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   output logic               instr_valid_o,
   output logic [1:0]         state_o,
   output logic               fault_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  tgt_q, tgt_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               ivalid_q, ivalid_d;
   logic               out_q, out_d;
   logic               pend_q, pend_d;
   logic               hpend_q, hpend_d;

   logic bad_br, br, hlt;
   logic start, req, ack;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign bad_br = branch_i & (branch_adrx_i[1:0] != 2'b00);
`else
   assign bad_br = 1'b0;
`endif

   assign br  = branch_i & ~bad_br;
   assign hlt = halt_i | bad_br;

   assign start = (state_q == FETCH) & run_i & ~hlt & ~branch_i
                & ~pend_q & ~hpend_q & ~out_q
                & (~ivalid_q | ~stall_i);
   assign req = (state_q == FETCH) & (out_q | start);
   assign ack = req & imem.imem_ack;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      tgt_d    = tgt_q;
      ipc_d    = ipc_q;
      instr_d  = instr_q;
      ivalid_d = ivalid_q & stall_i;
      out_d    = out_q;
      pend_d   = pend_q;
      hpend_d  = hpend_q;
      unique case (state_q)
         IDLE: begin
            if (bad_br) begin
               state_d  = HALTED;
               ivalid_d = 1'b0;
            end else begin
               if (br) begin
                  pc_d     = branch_adrx_i;
                  ivalid_d = 1'b0;
               end
               if (run_i) state_d = FETCH;
            end
         end
         FETCH: begin
            out_d = req & ~ack;
            if (~run_i & (~out_q | ack)) state_d = IDLE;
            // Halt waits out any in-flight fetch and drops its data.
            if (hlt | hpend_q) begin
               ivalid_d = 1'b0;
               pend_d   = 1'b0;
               if (out_q & ~ack) begin
                  hpend_d = 1'b1;
               end else begin
                  hpend_d = 1'b0;
                  state_d = HALTED;
               end
            end else if (ack) begin
               pend_d = 1'b0;
               if (br) begin
                  pc_d     = branch_adrx_i;
                  ivalid_d = 1'b0;
               end else if (pend_q) begin
                  pc_d = tgt_q;
               end else begin
                  instr_d  = imem.imem_rdata;
                  ipc_d    = pc_q;
                  ivalid_d = 1'b1;
                  pc_d     = pc_q + ADDR_W'(4);
               end
            end else if (br) begin
               ivalid_d = 1'b0;
               if (out_q) begin
                  pend_d = 1'b1;
                  tgt_d  = branch_adrx_i;
               end else begin
                  pc_d = branch_adrx_i;
               end
            end
         end
         HALTED: begin
            out_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_ADDR;
         tgt_q    <= '0;
         ipc_q    <= '0;
         instr_q  <= '0;
         ivalid_q <= 1'b0;
         out_q    <= 1'b0;
         pend_q   <= 1'b0;
         hpend_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         tgt_q    <= tgt_d;
         ipc_q    <= ipc_d;
         instr_q  <= instr_d;
         ivalid_q <= ivalid_d;
         out_q    <= out_d;
         pend_q   <= pend_d;
         hpend_q  <= hpend_d;
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
   logic fault_q;
   always_ff @(posedge clk) begin
      if (rst) fault_q <= 1'b0;
      else if (bad_br && state_q != HALTED) fault_q <= 1'b1;
   end
   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

   assign imem.imem_req  = req;
   assign imem.imem_adrx = pc_q;
   assign pc_o           = pc_q;
   assign instr_o        = instr_q;
   assign instr_pc_o     = ipc_q;
   assign instr_valid_o  = ivalid_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a delay-programmable imem model.
// Read data is 0xA5A50000 | address so each fetched word is traceable.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run, stall, branch, halt;
   logic [8:0]  badrx;
   logic [8:0]  pc, instr_pc;
   logic [31:0] instr;
   logic        ivalid, fault;
   logic [1:0]  state;

   int errs = 0;
   int checks = 0;
   int dly = 0;
   int wcnt;

   ifetch_ctrl_if #(.ADDR_W(9), .INSTR_W(32)) bus ();

   ifetch_ctrl #(.ADDR_W(9), .INSTR_W(32), .RESET_ADDR(9'd0)) dut (
      .clk(clk),
      .rst(rst),
      .run_i(run),
      .stall_i(stall),
      .branch_i(branch),
      .branch_adrx_i(badrx),
      .halt_i(halt),
      .imem(bus.master),
      .pc_o(pc),
      .instr_o(instr),
      .instr_pc_o(instr_pc),
      .instr_valid_o(ivalid),
      .state_o(state),
      .fault_o(fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst || !bus.imem_req || bus.imem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end
   assign bus.imem_ack   = bus.imem_req && (wcnt == dly);
   assign bus.imem_rdata = 32'hA5A5_0000 | {23'd0, bus.imem_adrx};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; run = 1'b0; stall = 1'b0;
      branch = 1'b0; halt = 1'b0; badrx = '0; dly = 0;
      tick; tick;
      rst = 1'b0;
      #1;
      checks++;
      if (pc !== 9'd0) begin
         $display("FAIL reset_pc got=%0h exp=0", pc); errs++;
      end
      checks++;
      if (state !== 2'd0) begin
         $display("FAIL reset_state got=%0d exp=0", state); errs++;
      end
      checks++;
      if (bus.imem_req !== 1'b0 || ivalid !== 1'b0) begin
         $display("FAIL reset_req_valid got=%b%b exp=00",
                  bus.imem_req, ivalid); errs++;
      end
      checks++;
      if (instr !== 32'd0 || instr_pc !== 9'd0 || fault !== 1'b0) begin
         $display("FAIL reset_regs got=%h/%h/%b exp=0/0/0",
                  instr, instr_pc, fault); errs++;
      end
   endtask

   task automatic test_stream;
      logic [8:0] a;
      run = 1'b1;
      tick;
      checks++;
      if (state !== 2'd1 || bus.imem_req !== 1'b1 || bus.imem_adrx !== 9'd0) begin
         $display("FAIL first_req got=%0d/%b/%0h exp=1/1/0",
                  state, bus.imem_req, bus.imem_adrx); errs++;
      end
      tick;
      checks++;
      if (ivalid !== 1'b1 || instr_pc !== 9'd0 || instr !== 32'hA5A5_0000) begin
         $display("FAIL first_instr got=%b/%0h/%h exp=1/0/a5a50000",
                  ivalid, instr_pc, instr); errs++;
      end
      for (int i = 1; i <= 128; i++) begin
         tick;
         a = 9'(4 * i);
         checks++;
         if (ivalid !== 1'b1 || instr_pc !== a
             || instr !== (32'hA5A5_0000 | {23'd0, a})) begin
            $display("FAIL stream_%0d got=%b/%0h/%h exp=1/%0h",
                     i, ivalid, instr_pc, instr, a); errs++;
         end
         if (i == 127) begin
            checks++;
            if (pc !== 9'd0) begin
               $display("FAIL pc_wrap got=%0h exp=0", pc); errs++;
            end
         end
      end
   endtask

   task automatic test_stall;
      stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++;
         if (bus.imem_req !== 1'b0 || ivalid !== 1'b1 || instr_pc !== 9'd0) begin
            $display("FAIL stall_hold_%0d got=%b/%b/%0h exp=0/1/0",
                     j, bus.imem_req, ivalid, instr_pc); errs++;
         end
         tick;
      end
      stall = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_adrx !== 9'd4) begin
         $display("FAIL stall_resume got=%b/%0h exp=1/4",
                  bus.imem_req, bus.imem_adrx); errs++;
      end
      tick;
      checks++;
      if (instr_pc !== 9'd4 || ivalid !== 1'b1) begin
         $display("FAIL stall_next got=%0h/%b exp=4/1", instr_pc, ivalid); errs++;
      end
   endtask

   task automatic test_branch_pending;
      rst = 1'b1; run = 1'b0;
      tick;
      rst = 1'b0;
      branch = 1'b1; badrx = 9'h010;
      tick;
      branch = 1'b0;
      checks++;
      if (pc !== 9'h010 || state !== 2'd0) begin
         $display("FAIL idle_branch got=%0h/%0d exp=10/0", pc, state); errs++;
      end
      dly = 3; run = 1'b1;
      tick;
      tick;
      branch = 1'b1; badrx = 9'h040;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_adrx !== 9'h010) begin
         $display("FAIL pend_d1 got=%b/%0h exp=1/10",
                  bus.imem_req, bus.imem_adrx); errs++;
      end
      tick;
      branch = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_adrx !== 9'h010 || ivalid !== 1'b0) begin
         $display("FAIL pend_d2 got=%b/%0h/%b exp=1/10/0",
                  bus.imem_req, bus.imem_adrx, ivalid); errs++;
      end
      tick;
      checks++;
      if (bus.imem_ack !== 1'b1 || bus.imem_adrx !== 9'h010) begin
         $display("FAIL pend_ack got=%b/%0h exp=1/10",
                  bus.imem_ack, bus.imem_adrx); errs++;
      end
      tick;
      checks++;
      if (ivalid !== 1'b0 || pc !== 9'h040 || bus.imem_adrx !== 9'h040
          || bus.imem_req !== 1'b1) begin
         $display("FAIL pend_redirect got=%b/%0h/%0h/%b exp=0/40/40/1",
                  ivalid, pc, bus.imem_adrx, bus.imem_req); errs++;
      end
      dly = 0;
      tick;
      checks++;
      if (ivalid !== 1'b1 || instr_pc !== 9'h040) begin
         $display("FAIL pend_target got=%b/%0h exp=1/40", ivalid, instr_pc); errs++;
      end
   endtask

   task automatic test_branch_ack;
      dly = 1;
      tick;
      branch = 1'b1; badrx = 9'h080;
      #1;
      checks++;
      if (bus.imem_ack !== 1'b1 || bus.imem_adrx !== 9'h044) begin
         $display("FAIL brack_setup got=%b/%0h exp=1/44",
                  bus.imem_ack, bus.imem_adrx); errs++;
      end
      tick;
      branch = 1'b0;
      checks++;
      if (ivalid !== 1'b0 || instr_pc !== 9'h040 || pc !== 9'h080
          || bus.imem_adrx !== 9'h080) begin
         $display("FAIL brack_discard got=%b/%0h/%0h/%0h exp=0/40/80/80",
                  ivalid, instr_pc, pc, bus.imem_adrx); errs++;
      end
      dly = 0;
      tick;
      checks++;
      if (ivalid !== 1'b1 || instr_pc !== 9'h080) begin
         $display("FAIL brack_target got=%b/%0h exp=1/80", ivalid, instr_pc); errs++;
      end
   endtask

   task automatic test_halt;
      dly = 3;
      tick;
      halt = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_adrx !== 9'h084) begin
         $display("FAIL halt_req got=%b/%0h exp=1/84",
                  bus.imem_req, bus.imem_adrx); errs++;
      end
      tick;
      halt = 1'b0;
      checks++;
      if (state !== 2'd1 || ivalid !== 1'b0) begin
         $display("FAIL halt_wait got=%0d/%b exp=1/0", state, ivalid); errs++;
      end
      tick;
      checks++;
      if (bus.imem_ack !== 1'b1 || state !== 2'd1) begin
         $display("FAIL halt_ackcyc got=%b/%0d exp=1/1", bus.imem_ack, state); errs++;
      end
      tick;
      checks++;
      if (state !== 2'd2 || ivalid !== 1'b0 || instr_pc !== 9'h080) begin
         $display("FAIL halted got=%0d/%b/%0h exp=2/0/80",
                  state, ivalid, instr_pc); errs++;
      end
      dly = 0;
      for (int k = 0; k < 10; k++) begin
         branch = (k == 4); badrx = 9'h020;
         #1;
         checks++;
         if (bus.imem_req !== 1'b0) begin
            $display("FAIL halted_req_%0d got=%b exp=0", k, bus.imem_req); errs++;
         end
         tick;
      end
      branch = 1'b0;
      checks++;
      if (pc !== 9'h084 || state !== 2'd2) begin
         $display("FAIL halted_hold got=%0h/%0d exp=84/2", pc, state); errs++;
      end
      rst = 1'b1;
      tick;
      rst = 1'b0; run = 1'b0;
      checks++;
      if (state !== 2'd0 || pc !== 9'd0) begin
         $display("FAIL halt_rst got=%0d/%0h exp=0/0", state, pc); errs++;
      end
   endtask

   task automatic test_align;
      run = 1'b1; dly = 0;
      tick;
      tick;
      branch = 1'b1; badrx = 9'h042;
      tick;
      branch = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      checks++;
      if (fault !== 1'b1 || state !== 2'd2 || pc !== 9'd4) begin
         $display("FAIL align_fault got=%b/%0d/%0h exp=1/2/4",
                  fault, state, pc); errs++;
      end
`else
      checks++;
      if (fault !== 1'b0 || pc !== 9'h042 || bus.imem_adrx !== 9'h042) begin
         $display("FAIL align_load got=%b/%0h/%0h exp=0/42/42",
                  fault, pc, bus.imem_adrx); errs++;
      end
      tick;
      checks++;
      if (instr_pc !== 9'h042 || pc !== 9'h046) begin
         $display("FAIL align_f1 got=%0h/%0h exp=42/46", instr_pc, pc); errs++;
      end
      tick;
      checks++;
      if (instr_pc !== 9'h046 || ivalid !== 1'b1) begin
         $display("FAIL align_f2 got=%0h/%b exp=46/1", instr_pc, ivalid); errs++;
      end
`endif
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_branch_pending;
      test_branch_ack;
      test_halt;
      test_align;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
